ddr4_dram_responder: RTL and testbench
======================================

Name: ddr4_dram_responder

Overview:
- Device-side responder for the DDR4 controller command/data interface: it plays the DRAM end of the link opposite ddr4_top.
- Decodes MRS, WR and RD commands and latches mode-register fields (CAS latency code, burst type, burst length).
- Accepts write bursts into an internal word array after a fixed write latency.
- Returns read bursts exactly CL cycles after an accepted RD, in sequential or interleaved burst order.
- Used as the synthesizable memory model behind the controller in system simulation and FPGA bring-up.

Parameters:
DQ_W, 16, data beat width
AW, 8, word-address bits; array depth is 2**AW
CWL, 3, cycles from WR acceptance to first write beat
TMRD, 4, cycles cmd_ready stays low after an accepted MRS

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command strobe
cmd  in  2  00 NOP, 01 MRS, 10 WR, 11 RD
cmd_addr  in  32  MRS: [7:3] CL code, [2] burst type (0 seq, 1 interleaved), [1:0] BL (00 BL8, 01 BC4, 10/11 BL8); WR/RD: [AW-1:0] start word address
cmd_ready  out  1  high when a command is accepted this cycle
wr_data  in  DQ_W  write beat, sampled during write-data cycles
rd_data  out  DQ_W  read beat; 0 when rd_valid is low
rd_valid  out  1  read beat qualifier
busy  out  1  high in any state other than IDLE
cl_cycles  out  6  decoded CAS latency currently in effect
cmd_err  out  1  one-cycle pulse when a command is dropped

Behaviour:
- Reset (asynchronous assert, synchronous release) forces the following values. The array contents are not cleared.
  - state IDLE, cmd_ready 1, rd_valid 0, rd_data 0, busy 0, cmd_err 0.
  - CL code 0 (cl_cycles 9), BL8, sequential burst type.
- Reset asserted mid-burst aborts the burst immediately.
  - Remaining write beats are discarded.
  - Beats already written remain in the array.
- A command is accepted when cmd_valid=1 and cmd_ready=1.
  - cmd_ready=1 only in IDLE.
  - cmd_valid=1 with cmd!=NOP while cmd_ready=0 drops the command and pulses cmd_err for one cycle.
  - NOP is always ignored.
- CL decode, code -> cycles:
  - 0-7 -> 9-16.
  - 8 -> 18, 9 -> 20, 10 -> 22, 11 -> 24, 12 -> 23, 13 -> 17, 14 -> 19, 15 -> 21.
  - 16 -> 25, 17 -> 26, 18 -> 28, 19 -> 29, 20 -> 30, 21 -> 32.
  - 22-31 are reserved and decode to 9.
- Beat count N: BL8 gives N=8, BC4 gives N=4.
- Burst block and ordering:
  - Start address S; base B = S with bits [2:0] cleared; s = S[2:0].
  - Beat i (0..N-1) addresses B + idx.
  - BL8 sequential: idx = (s+i) mod 8.
  - BL8 interleaved: idx = s XOR i.
  - BC4: the same rules applied within the aligned 4-word half containing s, using s[1:0] and mod 4.
- State machine:
  - IDLE -> MRD on MRS.
    - The fields are latched in the acceptance cycle and take effect for the next WR/RD.
    - MRD counts TMRD cycles, then returns to IDLE.
  - IDLE -> WR_WAIT on WR.
    - S and the burst mode are latched at acceptance (cycle T).
    - wr_data is sampled in cycles T+CWL .. T+CWL+N-1 (WR_DATA state), then the block returns to IDLE.
  - IDLE -> RD_WAIT on RD at cycle T.
    - rd_valid=1 in cycles T+CL .. T+CL+N-1 (RD_DATA state), one beat per cycle in burst order.
    - The block returns to IDLE the cycle after the last beat.
- Back-to-back: cmd_ready returns high on the cycle after the last data beat, or after MRD expires.
- Read-after-write of the same block returns the newly written data.
- Addresses wrap within the 2**AW array; bits above AW-1 are ignored.
- Latency counter: 6 bits, loaded with the latency minus 1 and decremented to 0. There is no off-by-one at CL=9 or CL=32.

Test Plan:
- Reset, then RD at address 0x10 with no MRS -> rd_valid rises exactly 9 cycles after acceptance for 8 beats; cl_cycles=9.
- MRS with CL code 13, BL8 sequential; WR at 0x23 with beats 0xA0..0xA7 starting 3 cycles later; RD at 0x20 -> data arrives 17 cycles after RD. Words 0x23..0x27 hold 0xA0..0xA4 and 0x20..0x22 hold 0xA5..0xA7.
- MRS with burst type interleaved, BC4, CL code 21; RD at 0x45 -> 4 beats from words 0x45, 0x44, 0x47, 0x46, starting 32 cycles after acceptance; busy drops the cycle after the last beat.
- WR issued during an MRD window and RD issued mid-burst -> both commands are dropped, cmd_err pulses once per attempt, and state and array are unaffected.
- Reset asserted after beat 3 of an 8-beat write -> outputs return to reset values asynchronously. A subsequent read shows beats 0-2 written and the rest unchanged.

Source files
------------

// File: rtl/ddr4_dram_responder_if.sv
// Command/data link between a DDR4 controller and the DRAM-side responder.
//   master : controller side; drives cmd_valid/cmd/cmd_addr/wr_data
//   slave  : responder side; drives cmd_ready, rd_data/rd_valid, busy,
//            cl_cycles, cmd_err
// cmd encoding: 00 NOP, 01 MRS, 10 WR, 11 RD.
interface ddr4_dram_responder_if #(
  parameter int DQ_W = 16
);
  logic            cmd_valid;
  logic [1:0]      cmd;
  logic [31:0]     cmd_addr;
  logic            cmd_ready;
  logic [DQ_W-1:0] wr_data;
  logic [DQ_W-1:0] rd_data;
  logic            rd_valid;
  logic            busy;
  logic [5:0]      cl_cycles;
  logic            cmd_err;

  modport master (
    output cmd_valid, cmd, cmd_addr, wr_data,
    input  cmd_ready, rd_data, rd_valid, busy, cl_cycles, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd, cmd_addr, wr_data,
    output cmd_ready, rd_data, rd_valid, busy, cl_cycles, cmd_err
  );
endinterface

// File: rtl/ddr4_dram_responder.sv
// DRAM end of the DDR4 controller link: decodes MRS/WR/RD, holds the mode
// register (CL code, burst type, burst length), stores write bursts into a
// 2**AW word array CWL cycles after WR and returns read bursts CL cycles
// after RD in sequential or interleaved order.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset (array contents are kept)
//   bus   : slave side of ddr4_dram_responder_if
// Parameters: DQ_W beat width, AW word-address bits (>= 3), CWL write
// latency (>= 2), TMRD mode-register recovery cycles (>= 1).
module ddr4_dram_responder #(
  parameter int DQ_W = 16,
  parameter int AW   = 8,
  parameter int CWL  = 3,
  parameter int TMRD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ddr4_dram_responder_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_MRD, S_WR_WAIT, S_WR_DATA, S_RD_WAIT, S_RD_DATA
  } state_e;

  typedef enum logic [1:0] {CMD_NOP, CMD_MRS, CMD_WR, CMD_RD} cmd_e;

  // Burst context captured when a WR/RD is accepted.
  typedef struct packed {
    logic [AW-1:0] start;
    logic          bc4;
    logic          inter;
  } burst_t;

  localparam logic [5:0] CWL_LD  = 6'(CWL - 1);
  localparam logic [5:0] TMRD_LD = 6'(TMRD - 1);

  function automatic logic [5:0] cl_decode(input logic [4:0] code);
    logic [5:0] c;
    if (code <= 5'd7) c = 6'd9 + {3'b000, code[2:0]};
    else begin
      case (code)
        5'd8:    c = 6'd18;
        5'd9:    c = 6'd20;
        5'd10:   c = 6'd22;
        5'd11:   c = 6'd24;
        5'd12:   c = 6'd23;
        5'd13:   c = 6'd17;
        5'd14:   c = 6'd19;
        5'd15:   c = 6'd21;
        5'd16:   c = 6'd25;
        5'd17:   c = 6'd26;
        5'd18:   c = 6'd28;
        5'd19:   c = 6'd29;
        5'd20:   c = 6'd30;
        5'd21:   c = 6'd32;
        default: c = 6'd9;   // reserved codes
      endcase
    end
    return c;
  endfunction

  // Word address of beat i; BC4 stays inside the aligned half holding s.
  function automatic logic [AW-1:0] beat_addr_f(input burst_t b, input logic [2:0] i);
    logic [2:0] s;
    logic [2:0] idx;
    logic [1:0] lo;
    s  = b.start[2:0];
    lo = b.inter ? (s[1:0] ^ i[1:0]) : (s[1:0] + i[1:0]);
    if (b.bc4) idx = {s[2], lo};
    else       idx = b.inter ? (s ^ i) : (s + i);
    return {b.start[AW-1:3], idx};
  endfunction

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      beat_q, beat_d;
  burst_t          burst_q, burst_d;
  logic [4:0]      cl_code_q, cl_code_d;
  logic            mr_bt_q, mr_bt_d;
  logic            mr_bc4_q, mr_bc4_d;

  logic [DQ_W-1:0] mem_q [2**AW];

  logic [5:0]      cl_cyc;
  logic            last_beat;
  logic [AW-1:0]   beat_addr;
  logic            wr_en;
  logic            unused_addr_bits;

  assign cl_cyc    = cl_decode(cl_code_q);
  assign last_beat = (beat_q == (burst_q.bc4 ? 3'd3 : 3'd7));
  assign beat_addr = beat_addr_f(burst_q, beat_q);
  assign wr_en     = (state_q == S_WR_DATA);
  assign unused_addr_bits = ^bus.cmd_addr[31:8];

  // Next-state logic. In the WAIT states cnt_q holds the number of cycles
  // still to go before the first beat, so the exit is taken at cnt_q == 1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    cl_code_d = cl_code_q;
    mr_bt_d   = mr_bt_q;
    mr_bc4_d  = mr_bc4_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            CMD_MRS: begin
              cl_code_d = bus.cmd_addr[7:3];
              mr_bt_d   = bus.cmd_addr[2];
              mr_bc4_d  = (bus.cmd_addr[1:0] == 2'b01);
              cnt_d     = TMRD_LD;
              state_d   = S_MRD;
            end
            CMD_WR: begin
              burst_d = '{start: bus.cmd_addr[AW-1:0], bc4: mr_bc4_q, inter: mr_bt_q};
              cnt_d   = CWL_LD;
              beat_d  = 3'd0;
              state_d = S_WR_WAIT;
            end
            CMD_RD: begin
              burst_d = '{start: bus.cmd_addr[AW-1:0], bc4: mr_bc4_q, inter: mr_bt_q};
              cnt_d   = cl_cyc - 6'd1;
              beat_d  = 3'd0;
              state_d = S_RD_WAIT;
            end
            default: ;
          endcase
        end
      end
      S_MRD: begin
        if (cnt_q == 6'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 6'd1;
      end
      S_WR_WAIT: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        beat_d = beat_q + 3'd1;
        if (last_beat) state_d = S_IDLE;
      end
      S_RD_WAIT: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        beat_d = beat_q + 3'd1;
        if (last_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      beat_q    <= '0;
      burst_q   <= '0;
      cl_code_q <= '0;
      mr_bt_q   <= 1'b0;
      mr_bc4_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      cl_code_q <= cl_code_d;
      mr_bt_q   <= mr_bt_d;
      mr_bc4_q  <= mr_bc4_d;
    end
  end

  // Array is deliberately not reset; reset forces IDLE asynchronously, which
  // drops wr_en, so a burst interrupted by reset stops writing at once.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[beat_addr] <= bus.wr_data;
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rd_valid  = (state_q == S_RD_DATA);
  assign bus.rd_data   = (state_q == S_RD_DATA) ? mem_q[beat_addr] : '0;
  assign bus.cl_cycles = cl_cyc;
  assign bus.cmd_err   = bus.cmd_valid && (bus.cmd != CMD_NOP) && (state_q != S_IDLE);

endmodule

// File: tb/tb_ddr4_dram_responder.sv
module tb_ddr4_dram_responder;
  localparam int DQ_W  = 16;
  localparam int AW    = 8;
  localparam int CWL   = 3;
  localparam int TMRD  = 4;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  ddr4_dram_responder_if #(.DQ_W(DQ_W)) bus();

  ddr4_dram_responder #(.DQ_W(DQ_W), .AW(AW), .CWL(CWL), .TMRD(TMRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DQ_W-1:0] mem_m [DEPTH];
  int              cl_tab [32];
  int              code_m;
  bit              bt_m, bc4_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Burst order from the ordering rules, plain integer arithmetic.
  function automatic int m_addr(input int start, input int i);
    int st, b, s, idx;
    st = start % DEPTH;
    b  = st - (st % 8);
    s  = st % 8;
    if (!bc4_m) idx = bt_m ? (s ^ i) : ((s + i) % 8);
    else        idx = (s / 4) * 4 + (bt_m ? ((s % 4) ^ i) : (((s % 4) + i) % 4));
    return b + idx;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // inj: 0 nothing, 1 occasional random command, 2 non-NOP every cycle
  task automatic drive(input int inj, output bit err_exp);
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'b00;
    bus.cmd_addr  = '0;
    bus.wr_data   = 16'($urandom);
    err_exp       = 1'b0;
    if (inj == 2 || (inj == 1 && $urandom_range(0, 3) == 0)) begin
      bus.cmd_valid = 1'b1;
      bus.cmd       = (inj == 2) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
      bus.cmd_addr  = $urandom;
      err_exp       = (bus.cmd != 2'b00);
    end
  endtask

  task automatic accept(input logic [1:0] c, input logic [31:0] a, input string tag);
    next_cyc();
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.cmd_addr  = a;
    #2;
    chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_err"},   32'(bus.cmd_err),   32'd0);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
    chk({tag, "_rdv"},   32'(bus.rd_valid),  32'd0);
    chk({tag, "_rdd"},   32'(bus.rd_data),   32'd0);
    chk({tag, "_err"},   32'(bus.cmd_err),   32'd0);
    chk({tag, "_cl"},    32'(bus.cl_cycles), 32'd9);
  endtask

  task automatic do_mrs(input int code, input int bt, input int bl, input int inj);
    bit e;
    accept(2'b01, 32'((code << 3) | (bt << 2) | bl) | ($urandom & 32'hffff_ff00), "mrs");
    code_m = code;
    bt_m   = (bt != 0);
    bc4_m  = (bl == 1);
    for (int k = 1; k <= TMRD + 1; k++) begin
      next_cyc();
      drive((k <= TMRD) ? inj : 0, e);
      #2;
      if (k <= TMRD) begin
        chk("mrd_busy",  32'(bus.busy),      32'd1);
        chk("mrd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("mrd_err",   32'(bus.cmd_err),   32'(e));
      end else begin
        chk("mrd_done",  32'(bus.busy),      32'd0);
        chk("cl_cycles", 32'(bus.cl_cycles), 32'(cl_tab[code_m]));
      end
    end
  endtask

  task automatic do_wr(input logic [31:0] a, input int inj, input bit rnd, input logic [15:0] base);
    logic [DQ_W-1:0] d [8];
    int n;
    bit e;
    n = bc4_m ? 4 : 8;
    for (int i = 0; i < 8; i++) d[i] = rnd ? 16'($urandom) : base + 16'(i);
    accept(2'b10, a, "wr");
    for (int k = 1; k <= CWL + n; k++) begin
      next_cyc();
      drive((k < CWL + n) ? inj : 0, e);
      if (k >= CWL && k < CWL + n) begin
        bus.wr_data = d[k-CWL];
        mem_m[m_addr(int'(a[AW-1:0]), k - CWL)] = d[k-CWL];
      end
      #2;
      if (k < CWL + n) begin
        chk("wr_busy", 32'(bus.busy),     32'd1);
        chk("wr_rdv",  32'(bus.rd_valid), 32'd0);
        chk("wr_rdd",  32'(bus.rd_data),  32'd0);
        chk("wr_err",  32'(bus.cmd_err),  32'(e));
      end else begin
        chk("wr_done",  32'(bus.busy),      32'd0);
        chk("wr_ready", 32'(bus.cmd_ready), 32'd1);
      end
    end
  endtask

  task automatic do_rd(input logic [31:0] a, input int inj);
    int cl, n;
    bit e, v;
    cl = cl_tab[code_m];
    n  = bc4_m ? 4 : 8;
    accept(2'b11, a, "rd");
    chk("rd_cl", 32'(bus.cl_cycles), 32'(cl));
    for (int k = 1; k <= cl + n; k++) begin
      next_cyc();
      drive((k < cl + n) ? inj : 0, e);
      #2;
      v = (k >= cl && k < cl + n);
      chk("rd_valid", 32'(bus.rd_valid), 32'(v));
      chk("rd_data",  32'(bus.rd_data),
          v ? 32'(mem_m[m_addr(int'(a[AW-1:0]), k - cl)]) : 32'd0);
      if (k < cl + n) begin
        chk("rd_busy", 32'(bus.busy),    32'd1);
        chk("rd_err",  32'(bus.cmd_err), 32'(e));
      end else begin
        chk("rd_done", 32'(bus.busy), 32'd0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DQ_W-1:0] d5 [8];
    bit e;
    for (int i = 0; i < 8; i++) cl_tab[i] = 9 + i;
    cl_tab[8]  = 18; cl_tab[9]  = 20; cl_tab[10] = 22; cl_tab[11] = 24;
    cl_tab[12] = 23; cl_tab[13] = 17; cl_tab[14] = 19; cl_tab[15] = 21;
    cl_tab[16] = 25; cl_tab[17] = 26; cl_tab[18] = 28; cl_tab[19] = 29;
    cl_tab[20] = 30; cl_tab[21] = 32;
    for (int i = 22; i < 32; i++) cl_tab[i] = 9;
    code_m = 0; bt_m = 0; bc4_m = 0;
    bus.cmd_valid = 1'b0; bus.cmd = 2'b00; bus.cmd_addr = '0; bus.wr_data = '0;

    repeat (2) @(posedge clk);
    #3;
    rst_chk("rst");
    rst_n = 1'b1;

    // Give every word a known value.
    for (int b = 0; b < DEPTH / 8; b++) do_wr(32'(b * 8), 0, 1'b1, 16'h0);

    // Default CL 9, BL8 sequential.
    do_rd(32'h10, 0);

    // CL code 13 (17 cycles), wrapped sequential write then aligned read.
    do_mrs(13, 0, 0, 0);
    do_wr(32'h23, 0, 1'b0, 16'h00A0);
    do_rd(32'h20, 0);

    // Interleaved BC4, CL code 21 (32 cycles).
    do_mrs(21, 1, 1, 0);
    do_rd(32'h45, 0);

    // Commands issued while busy are dropped.
    do_mrs(5, 0, 0, 2);
    do_wr($urandom, 2, 1'b1, 16'h0);
    do_rd($urandom, 2);

    // Randomized mix, upper address bits random, reserved CL codes included.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 2))
        0:       do_mrs($urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 3), 1);
        1:       do_wr($urandom, 1, 1'b1, 16'h0);
        default: do_rd($urandom, 1);
      endcase
    end

    // Reset during beat 3 of an 8-beat write: beats 0-2 land, rest do not.
    do_mrs(6, 0, 0, 0);
    for (int i = 0; i < 8; i++) d5[i] = 16'($urandom);
    accept(2'b10, 32'h30, "wr5");
    for (int k = 1; k < CWL + 3; k++) begin
      next_cyc();
      drive(0, e);
      if (k >= CWL) begin
        bus.wr_data = d5[k-CWL];
        mem_m[m_addr(32'h30, k - CWL)] = d5[k-CWL];
      end
    end
    next_cyc();
    drive(0, e);
    bus.wr_data = d5[3];
    #2;
    chk("wr5_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    rst_chk("arst");
    code_m = 0; bt_m = 0; bc4_m = 0;
    repeat (2) next_cyc();
    rst_n = 1'b1;
    do_rd(32'h30, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
